bank_write_ctrl: RTL and testbench
==================================

BANK_WRITE_CTRL -- requirements
Module: bank_write_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_DEPTH, default 512: bank depth in words; address width AW = $clog2(ADDRESS_DEPTH).
REQ-002 SHALL have parameter PIXEL_WIDTH, default 32: width of one pixel, equal to one bank block width.
REQ-003 SHALL have parameter PIXELS_PER_WORD, default 4: pixels per bank word, equal to the bank block count.
REQ-004 SHALL have parameter FRAME_WORDS, default 512: maximum words per frame, 1..ADDRESS_DEPTH.
REQ-005 SHALL have derived parameter BANDWIDTH = PIXEL_WIDTH*PIXELS_PER_WORD.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse that starts a frame.
REQ-009 SHALL have port pix_valid, input, 1 bit: pixel present.
REQ-010 SHALL have port pix_data, input, PIXEL_WIDTH bits: pixel value.
REQ-011 SHALL have port pix_last, input, 1 bit: marks the final pixel of the frame.
REQ-012 SHALL have port pix_ready, output, 1 bit: the controller accepts a pixel this cycle.
REQ-013 SHALL have port cea, output, 1 bit: bank write enable.
REQ-014 SHALL have port oce, output, 1 bit: bank output clock enable.
REQ-015 SHALL have port ada, output, AW bits: bank write address.
REQ-016 SHALL have port din, output, BANDWIDTH bits: bank write data.
REQ-017 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-019 SHALL have port frame_words, output, AW+1 bits: number of words written in the last completed frame.

Function
REQ-020 SHALL implement the states IDLE, FILL and DONE.
REQ-021 SHALL, in IDLE, hold pix_ready=0 and, on frame_start, clear the word address, lane index and pack register, then enter FILL.
REQ-022 SHALL, in FILL, hold pix_ready=1; a pixel is accepted when pix_valid=1 and pix_ready=1.
REQ-023 SHALL write an accepted pixel into lane index L of the pack register, at bits [L*PIXEL_WIDTH +: PIXEL_WIDTH], with lane 0 as the first pixel, then increment L.
REQ-024 SHALL treat a word as complete when the accepted pixel has L = PIXELS_PER_WORD-1 or pix_last = 1.
REQ-025 SHALL, on the completing edge, register din (including the current pixel), set ada = the word address, assert cea in the following cycle for exactly one cycle, increment the word address, and reset L to 0.
REQ-026 SHALL drive lanes left unfilled by a pix_last-terminated word with zero.
REQ-027 SHALL accept pixels back to back: pixel acceptance continues in the same cycle in which cea is high, with no bubbles.
REQ-028 SHALL move from FILL to DONE when a word completes with pix_last = 1.
REQ-029 SHALL move from FILL to DONE when the completed word is at address FRAME_WORDS-1 (frame full); pixels after that point are not accepted.
REQ-030 SHALL, in DONE (one cycle), pulse frame_done=1, latch frame_words with the count of words written, hold pix_ready=0, then return to IDLE.
REQ-031 SHALL ignore frame_start in the DONE state.
REQ-032 SHALL, on frame_start in FILL, restart the frame: discard the partial word, reset address and L to 0, generate no cea for the discarded data, and leave frame_done unpulsed.
REQ-033 SHALL hold the write address strictly below FRAME_WORDS, so that no wrap occurs within a frame.
REQ-034 SHALL hold oce = 1 whenever resetn is high.
REQ-035 SHALL not accept pixels in IDLE or DONE, even when pix_valid=1; upstream holds them.

Reset
REQ-036 SHALL, while resetn=0, force state IDLE and drive pix_ready=0, cea=0, oce=0, ada=0, din=0, busy=0, frame_done=0 and frame_words=0.
REQ-037 SHALL treat reset asserted mid-frame as discarding all partial data, with no cea after reset is released.

Verification (PIXELS_PER_WORD=4, FRAME_WORDS=4, PIXEL_WIDTH=32)
REQ-038 SHALL cover a full frame: frame_start, then 16 back-to-back pixels 0x01..0x10 with pix_last on 0x10 -> cea pulses at ada 0..3, word 0 = 0x00000004_00000003_00000002_00000001, then frame_done and frame_words=4.
REQ-039 SHALL cover a short frame: 6 pixels with pix_last on the 6th -> 2 writes, word 1 = {0,0,px6,px5}, frame_words=2.
REQ-040 SHALL cover overrun: 17 pixels without pix_last -> 4 writes, pix_ready drops after the 16th pixel, the 17th pixel is not accepted, and frame_done fires.
REQ-041 SHALL cover backpressure: pixels offered in IDLE before frame_start -> pix_ready=0 and no cea until frame_start.
REQ-042 SHALL cover restart: frame_start after 3 pixels of a frame -> no write of those pixels, the next 4 pixels are written at ada=0.
REQ-043 SHALL cover reset mid-frame: resetn low after 5 pixels -> all outputs are at reset values immediately, and no cea or frame_done follows after release.

Source files
------------

// File: rtl/bank_write_ctrl.sv
// Packs an incoming pixel stream into bank-wide words and drives the bank
// write port, one word per frame address, with frame start/restart/end control.
//
// state  | meaning
// IDLE   | waiting for frame_start, no pixels accepted
// FILL   | accepting pixels, packing lanes, issuing word writes
// DONE   | one-cycle frame end: frame_done pulse, frame_words latched
module bank_write_ctrl #(
    parameter int ADDRESS_DEPTH   = 512,
    parameter int PIXEL_WIDTH     = 32,
    parameter int PIXELS_PER_WORD = 4,
    parameter int FRAME_WORDS     = 512,
    localparam int AW             = $clog2(ADDRESS_DEPTH),
    localparam int BANDWIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic                   pix_last,
    output logic                   pix_ready,
    output logic                   cea,
    output logic                   oce,
    output logic [AW-1:0]          ada,
    output logic [BANDWIDTH-1:0]   din,
    output logic                   busy,
    output logic                   frame_done,
    output logic [AW:0]            frame_words
);

    localparam int LW = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [AW:0]          word_cnt;
    logic [LW-1:0]        lane;
    logic [BANDWIDTH-1:0] pack;
    logic [BANDWIDTH-1:0] pack_next;
    logic                 accept;
    logic                 lane_last;
    logic                 last_word;
    logic                 word_done;
    logic                 start_clear;

    // A frame_start in FILL wins over a pixel offered in the same cycle.
    assign accept      = pix_ready && pix_valid && !frame_start;
    assign lane_last   = (lane == LW'(PIXELS_PER_WORD - 1));
    assign last_word   = (word_cnt == (AW+1)'(FRAME_WORDS - 1));
    assign word_done   = accept && (lane_last || pix_last);
    assign start_clear = frame_start && (state == S_IDLE || state == S_FILL);
    assign oce         = resetn;

    always_comb begin
        pack_next = pack;
        pack_next[lane*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_next = S_FILL;
            end
            S_FILL: begin
                if (frame_start) begin
                    state_next = S_FILL;
                end else if (word_done && (pix_last || last_word)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = (state == S_FILL);
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
    end

    // Pack register is zeroed after each word so short final words pad with zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt    <= '0;
            lane        <= '0;
            pack        <= '0;
            din         <= '0;
            ada         <= '0;
            cea         <= 1'b0;
            frame_words <= '0;
        end else begin
            cea <= 1'b0;
            if (start_clear) begin
                word_cnt <= '0;
                lane     <= '0;
                pack     <= '0;
            end else if (word_done) begin
                din      <= pack_next;
                ada      <= word_cnt[AW-1:0];
                cea      <= 1'b1;
                word_cnt <= word_cnt + 1'b1;
                lane     <= '0;
                pack     <= '0;
                if (state_next == S_DONE) frame_words <= word_cnt + 1'b1;
            end else if (accept) begin
                pack <= pack_next;
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Directed bench for bank_write_ctrl with 4 pixels per word and 4-word frames.
module tb_bank_write_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         frame_start;
    logic         pix_valid;
    logic [31:0]  pix_data;
    logic         pix_last;
    logic         pix_ready;
    logic         cea;
    logic         oce;
    logic [8:0]   ada;
    logic [127:0] din;
    logic         busy;
    logic         frame_done;
    logic [9:0]   frame_words;

    int checks = 0;
    int errors = 0;
    int wr_n   = 0;
    int done_n = 0;
    int base;
    int dbase;
    logic [127:0] wr_din [0:63];
    logic [8:0]   wr_ada [0:63];

    bank_write_ctrl #(
        .ADDRESS_DEPTH   (512),
        .PIXEL_WIDTH     (32),
        .PIXELS_PER_WORD (4),
        .FRAME_WORDS     (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .cea         (cea),
        .oce         (oce),
        .ada         (ada),
        .din         (din),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_words (frame_words)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cea) begin
            if (wr_n < 64) begin
                wr_din[wr_n] = din;
                wr_ada[wr_n] = ada;
            end
            wr_n++;
        end
        if (frame_done) done_n++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic l);
        @(negedge clk);
        frame_start = s;
        pix_valid   = v;
        pix_data    = d;
        pix_last    = l;
    endtask

    initial begin
        resetn = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        pix_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", pix_ready, 0);
        chk("rst_cea", cea, 0);
        chk("rst_oce", oce, 0);
        chk("rst_ada", ada, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_words", frame_words, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1 chk("oce_run", oce, 1);

        // pixels offered in IDLE are held off
        base = wr_n;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'hEE, 0);
            chk("bp_ready", pix_ready, 0);
            chk("bp_busy", busy, 0);
        end
        chk("bp_writes", wr_n - base, 0);

        // full frame of 16 pixels
        base = wr_n;
        dbase = done_n;
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 32'(i), i == 16);
            chk("ff_ready", pix_ready, 1);
        end
        drive(0, 0, 0, 0);
        chk("ff_done", frame_done, 1);
        chk("ff_words", frame_words, 4);
        chk("ff_done_ready", pix_ready, 0);
        chk("ff_done_busy", busy, 1);
        drive(0, 0, 0, 0);
        chk("ff_idle_busy", busy, 0);
        chk("ff_idle_done", frame_done, 0);
        chk("ff_nwr", wr_n - base, 4);
        for (int k = 0; k < 4; k++) chk("ff_ada", wr_ada[base+k], 128'(k));
        chk("ff_din0", wr_din[base], 128'h00000004_00000003_00000002_00000001);
        chk("ff_din3", wr_din[base+3], 128'h00000010_0000000f_0000000e_0000000d);
        chk("ff_ndone", done_n - dbase, 1);

        // short frame with zero-padded final word
        base = wr_n;
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) drive(0, 1, 32'hA0 + 32'(i), i == 6);
        drive(0, 0, 0, 0);
        chk("sf_done", frame_done, 1);
        chk("sf_words", frame_words, 2);
        drive(0, 0, 0, 0);
        chk("sf_nwr", wr_n - base, 2);
        chk("sf_din0", wr_din[base], 128'h000000A4_000000A3_000000A2_000000A1);
        chk("sf_din1", wr_din[base+1], 128'h00000000_00000000_000000A6_000000A5);
        chk("sf_ada1", wr_ada[base+1], 1);

        // overrun: 17 pixels, no pix_last
        base = wr_n;
        dbase = done_n;
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            drive(0, 1, 32'h100 + 32'(i), 0);
            if (i <= 16) begin
                chk("ov_ready", pix_ready, 1);
            end else begin
                chk("ov_ready17", pix_ready, 0);
                chk("ov_done", frame_done, 1);
            end
        end
        drive(0, 0, 0, 0);
        chk("ov_words", frame_words, 4);
        chk("ov_idle_ready", pix_ready, 0);
        repeat (3) drive(0, 0, 0, 0);
        chk("ov_nwr", wr_n - base, 4);
        chk("ov_ada3", wr_ada[base+3], 3);
        chk("ov_din3", wr_din[base+3], 128'h00000110_0000010f_0000010e_0000010d);
        chk("ov_ndone", done_n - dbase, 1);

        // restart after 3 pixels
        base = wr_n;
        dbase = done_n;
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(0, 1, 32'hB0 + 32'(i), 0);
        drive(1, 0, 0, 0);
        chk("rs_busy", busy, 1);
        chk("rs_nodone", done_n - dbase, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, 32'hC0 + 32'(i), i == 4);
        drive(0, 0, 0, 0);
        chk("rs_done", frame_done, 1);
        chk("rs_words", frame_words, 1);
        drive(0, 0, 0, 0);
        chk("rs_nwr", wr_n - base, 1);
        chk("rs_ada", wr_ada[base], 0);
        chk("rs_din", wr_din[base], 128'h000000C4_000000C3_000000C2_000000C1);
        chk("rs_ndone", done_n - dbase, 1);

        // reset in the middle of a frame
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) drive(0, 1, 32'hD0 + 32'(i), 0);
        @(negedge clk);
        resetn = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk("mr_ready", pix_ready, 0);
        chk("mr_cea", cea, 0);
        chk("mr_oce", oce, 0);
        chk("mr_ada", ada, 0);
        chk("mr_din", din, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", frame_done, 0);
        chk("mr_words", frame_words, 0);
        base = wr_n;
        dbase = done_n;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("mr_nwr", wr_n - base, 0);
        chk("mr_ndone", done_n - dbase, 0);
        chk("mr_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
